// File: rtl/fsm_flow_pkg.sv
// fsm_flow_pkg: shared definitions for the TLP flow-control FSM.
//   - one-hot state encodings and state width
//   - default watermark constants
//   - clamp_low(): keeps the low watermark strictly below the high watermark
package fsm_flow_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
  localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

  localparam int TH_HIGH_DEF_C = 6;
  localparam int TH_LOW_DEF_C  = 2;

  // A low watermark at or above the high one would defeat the hysteresis
  // band, so pull it to one below high (never below zero).
  function automatic int unsigned clamp_low(input int unsigned hi,
                                            input int unsigned lo);
    if (lo >= hi) begin
      return (hi == 0) ? 0 : hi - 1;
    end
    return lo;
  endfunction

endpackage

// File: rtl/fsm_ch_hyst.sv
// fsm_ch_hyst: per-channel watermark hysteresis and resume-pulse generator.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   count_i        FIFO occupancy of this channel
//   th_high/th_low latched watermarks
//   active         next state is ACTIVE: run the hysteresis
//   force_pause    next state is ERROR: hold pause high
//   clr            next state is RESET/INIT/IDLE: drop pause silently
//   pause_i        registered pause flag
//   continue_i     one-cycle pulse on a hysteresis-driven pause release
module fsm_ch_hyst #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] th_high,
  input  logic [CNT_W-1:0] th_low,
  input  logic             active,
  input  logic             force_pause,
  input  logic             clr,
  output logic             pause_i,
  output logic             continue_i
);

  logic pause_next;

  // Set has priority; between the watermarks the flag holds.
  always_comb begin
    pause_next = pause_i;
    if (count_i >= th_high) begin
      pause_next = 1'b1;
    end else if (count_i <= th_low) begin
      pause_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_i    <= 1'b0;
      continue_i <= 1'b0;
    end else if (force_pause) begin
      pause_i    <= 1'b1;
      continue_i <= 1'b0;
    end else if (clr) begin
      // Leaving ACTIVE/ERROR releases pause without a resume pulse.
      pause_i    <= 1'b0;
      continue_i <= 1'b0;
    end else if (active) begin
      pause_i    <= pause_next;
      continue_i <= pause_i & ~pause_next;
    end else begin
      continue_i <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_flow_ctrl.sv
// fsm_flow_ctrl: flow-control FSM for the TLP datapath. Watches NUM_CH FIFO
// occupancies and drives per-channel pause / resume pulse / sticky overflow
// error flags, plus idle and init status for the muxes.
// Ports:
//   clk, reset       clock and asynchronous active-low reset
//   init             level request to enter INIT and reload thresholds
//   th_high_in/_low  watermarks sampled while in INIT
//   fifo_count       packed occupancy, channel i at [i*CNT_W +: CNT_W]
//   fifo_empty/full  per-channel FIFO status
//   fifo_wr          per-channel push attempt
//   pause            stop sending on the channel
//   continue_pulse   one-cycle resume pulse
//   error_full       sticky overflow flag
//   idle, init_out   status: FSM in IDLE / INIT
//   state_out        one-hot current state
// Build option: FSM_AUTO_RECOVER_EN enables automatic ERROR -> INIT once every
// errored channel has reported empty for two consecutive cycles.
module fsm_flow_ctrl
  import fsm_flow_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int TH_HIGH_DEF = TH_HIGH_DEF_C,
  parameter int TH_LOW_DEF  = TH_LOW_DEF_C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [CNT_W-1:0]        th_high_in,
  input  logic [CNT_W-1:0]        th_low_in,
  input  logic [NUM_CH*CNT_W-1:0] fifo_count,
  input  logic [NUM_CH-1:0]       fifo_empty,
  input  logic [NUM_CH-1:0]       fifo_full,
  input  logic [NUM_CH-1:0]       fifo_wr,
  output logic [NUM_CH-1:0]       pause,
  output logic [NUM_CH-1:0]       continue_pulse,
  output logic [NUM_CH-1:0]       error_full,
  output logic                    idle,
  output logic                    init_out,
  output logic [STATE_W-1:0]      state_out
);

  logic [STATE_W-1:0] state, next_state;
  logic [CNT_W-1:0]   th_high, th_low, th_low_clamped;
  logic [NUM_CH-1:0]  overflow, error_full_next;
  logic               ovf_hit, all_empty;
  logic               ns_active, ns_error, ns_clr;

  assign overflow  = fifo_wr & fifo_full;
  assign ovf_hit   = ((state == ST_IDLE) || (state == ST_ACTIVE)) && (|overflow);
  assign all_empty = &fifo_empty;
  assign th_low_clamped = CNT_W'(clamp_low(32'(th_high_in), 32'(th_low_in)));

`ifdef FSM_AUTO_RECOVER_EN
  logic rec_ok, rec_seen, recover;
  // Only channels carrying an error must drain; clean channels are ignored.
  assign rec_ok  = &(fifo_empty | ~error_full);
  assign recover = rec_ok & rec_seen;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   next_state = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (ovf_hit)         next_state = ST_ERROR;
        else if (init)       next_state = ST_INIT;
        else if (!all_empty) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ovf_hit)        next_state = ST_ERROR;
        else if (init)      next_state = ST_INIT;
        else if (all_empty) next_state = ST_IDLE;
      end
      ST_ERROR: begin
        if (init) next_state = ST_INIT;
`ifdef FSM_AUTO_RECOVER_EN
        else if (recover) next_state = ST_INIT;
`endif
      end
      default:   next_state = ST_RESET;
    endcase
  end

  // Entering INIT wipes the sticky errors; otherwise new overflows accumulate.
  always_comb begin
    error_full_next = error_full;
    if (next_state == ST_INIT) begin
      error_full_next = '0;
    end else if ((state != ST_RESET) && (state != ST_INIT)) begin
      error_full_next = error_full | overflow;
    end
  end

  // Outputs are registered from next_state so they line up with the new state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RESET;
      error_full <= '0;
      idle       <= 1'b0;
      init_out   <= 1'b0;
      th_high    <= CNT_W'(TH_HIGH_DEF);
      th_low     <= CNT_W'(TH_LOW_DEF);
    end else begin
      state      <= next_state;
      error_full <= error_full_next;
      idle       <= (next_state == ST_IDLE);
      init_out   <= (next_state == ST_INIT);
      if (state == ST_INIT) begin
        th_high <= th_high_in;
        th_low  <= th_low_clamped;
      end
    end
  end

`ifdef FSM_AUTO_RECOVER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_seen <= 1'b0;
    end else begin
      rec_seen <= (state == ST_ERROR) && (next_state == ST_ERROR) && rec_ok;
    end
  end
`endif

  assign state_out = state;
  assign ns_active = (next_state == ST_ACTIVE);
  assign ns_error  = (next_state == ST_ERROR);
  assign ns_clr    = !(ns_active || ns_error);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fsm_ch_hyst #(
      .CNT_W (CNT_W)
    ) u_hyst (
      .clk         (clk),
      .reset       (reset),
      .count_i     (fifo_count[i*CNT_W +: CNT_W]),
      .th_high     (th_high),
      .th_low      (th_low),
      .active      (ns_active),
      .force_pause (ns_error),
      .clr         (ns_clr),
      .pause_i     (pause[i]),
      .continue_i  (continue_pulse[i])
    );
  end

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// tb_fsm_flow_ctrl: directed bench for fsm_flow_ctrl (4 channels, 4-bit counts).
module tb_fsm_flow_ctrl;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [3:0]  th_high_in, th_low_in;
  logic [15:0] fifo_count;
  logic [3:0]  fifo_empty, fifo_full, fifo_wr;
  logic [3:0]  pause, continue_pulse, error_full;
  logic        idle, init_out;
  logic [4:0]  state_out;

  int total = 0;
  int bad   = 0;

  fsm_flow_ctrl #(
    .NUM_CH      (4),
    .CNT_W       (4),
    .TH_HIGH_DEF (6),
    .TH_LOW_DEF  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .th_high_in     (th_high_in),
    .th_low_in      (th_low_in),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_wr        (fifo_wr),
    .pause          (pause),
    .continue_pulse (continue_pulse),
    .error_full     (error_full),
    .idle           (idle),
    .init_out       (init_out),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [4:0] st, input logic [3:0] p,
                            input logic [3:0] c, input logic [3:0] ef,
                            input logic idl, input logic io);
    chk({tag, ".state"}, 32'(state_out), 32'(st));
    chk({tag, ".pause"}, 32'(pause), 32'(p));
    chk({tag, ".cont"}, 32'(continue_pulse), 32'(c));
    chk({tag, ".err"}, 32'(error_full), 32'(ef));
    chk({tag, ".idle"}, 32'(idle), 32'(idl));
    chk({tag, ".init"}, 32'(init_out), 32'(io));
  endtask

  task automatic set_cnt(input int ch, input logic [3:0] v);
    fifo_count[ch*4 +: 4] = v;
  endtask

  initial begin
    reset = 1'b0; init = 1'b1; th_high_in = 4'd0; th_low_in = 4'd0;
    fifo_count = '0; fifo_empty = 4'hF; fifo_full = '0; fifo_wr = '0;

    // reset held for 3 cycles
    tick(); tick(); tick();
    expect_all("rst", S_RESET, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    reset = 1'b1;
    tick();
    expect_all("to_init", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    th_high_in = 4'd5; th_low_in = 4'd1;
    tick();
    expect_all("hold_init", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    init = 1'b0;
    tick();
    expect_all("to_idle", S_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // ch2 ramp with watermarks 5/1
    fifo_empty = 4'b1011;
    tick();
    expect_all("to_active", S_ACTIVE, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    for (int c = 1; c <= 6; c++) begin
      set_cnt(2, 4'(c));
      tick();
      chk($sformatf("up%0d.pause", c), 32'(pause), (c >= 5) ? 32'h4 : 32'h0);
      chk($sformatf("up%0d.cont", c), 32'(continue_pulse), 32'h0);
    end
    for (int c = 5; c >= 0; c--) begin
      set_cnt(2, 4'(c));
      tick();
      chk($sformatf("dn%0d.pause", c), 32'(pause), (c > 1) ? 32'h4 : 32'h0);
      chk($sformatf("dn%0d.cont", c), 32'(continue_pulse), (c == 1) ? 32'h4 : 32'h0);
    end
    chk("ramp.state", 32'(state_out), 32'(S_ACTIVE));

    fifo_empty = 4'hF;
    tick();
    expect_all("drain_idle", S_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // reload with low >= high: effective low becomes 2
    init = 1'b1; th_high_in = 4'd3; th_low_in = 4'd7;
    tick();
    expect_all("reinit", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    init = 1'b0;
    tick();
    expect_all("idle2", S_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    fifo_empty = 4'b1110; set_cnt(0, 4'd4);
    tick();
    expect_all("c0_4", S_ACTIVE, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
    set_cnt(0, 4'd3);
    tick();
    chk("c0_3.pause", 32'(pause), 32'h1);
    set_cnt(0, 4'd2);
    tick();
    chk("c0_2.pause", 32'(pause), 32'h0);
    chk("c0_2.cont", 32'(continue_pulse), 32'h1);
    tick();
    chk("c0_2b.cont", 32'(continue_pulse), 32'h0);

    // overflow beats a simultaneous init
    fifo_full = 4'b1001; fifo_wr = 4'b1001; init = 1'b1;
    tick();
    expect_all("ovf", S_ERROR, 4'hF, 4'h0, 4'b1001, 1'b0, 1'b0);

    fifo_full = 4'b0100; fifo_wr = 4'b0100; init = 1'b0;
    tick();
    expect_all("ovf_or", S_ERROR, 4'hF, 4'h0, 4'b1101, 1'b0, 1'b0);

    fifo_full = '0; fifo_wr = '0; init = 1'b1;
    tick();
    expect_all("err_init", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    init = 1'b0; fifo_empty = 4'hF; set_cnt(0, 4'd0);
    tick();
    expect_all("idle3", S_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // asynchronous reset in the middle of ACTIVE
    fifo_empty = 4'b1011; set_cnt(2, 4'd5);
    tick();
    expect_all("pre_rst", S_ACTIVE, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_all("async_rst", S_RESET, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1; set_cnt(2, 4'd0); fifo_empty = 4'hF;
    tick();
    expect_all("rst_init", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    expect_all("idle4", S_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // ch1 error, then ch1 reports empty for two cycles
    fifo_empty = 4'b1101; fifo_full = 4'b0010; fifo_wr = 4'b0010;
    tick();
    expect_all("err1", S_ERROR, 4'hF, 4'h0, 4'b0010, 1'b0, 1'b0);
    fifo_full = '0; fifo_wr = '0;
    tick();
    chk("err1_hold.state", 32'(state_out), 32'(S_ERROR));
    fifo_empty = 4'hF;
    tick();
    chk("rec1.state", 32'(state_out), 32'(S_ERROR));
    tick();
`ifdef FSM_AUTO_RECOVER_EN
    expect_all("rec2", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
`else
    expect_all("rec2", S_ERROR, 4'hF, 4'h0, 4'b0010, 1'b0, 1'b0);
`endif
    init = 1'b1;
    tick();
    expect_all("final_init", S_INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_flow_ctrl.md
Name: fsm_flow_ctrl

Overview:
Parametrised flow-control state machine for the TLP datapath. It watches the occupancy of NUM_CH FIFOs and drives per-channel pause, continue and error_full flags to the upstream sources. It also drives idle and init status to the muxes. Thresholds are programmable and latched during INIT, with hysteresis between the high and low watermarks. Overflow produces a sticky per-channel error.

Parameters:
NUM_CH, 4, number of FIFO channels
CNT_W, 4, width of each FIFO occupancy count (FIFO depth 8 gives 0..8)
TH_HIGH_DEF, 6, reset value of the high watermark
TH_LOW_DEF, 2, reset value of the low watermark

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  level request to enter INIT and reload thresholds
th_high_in  in  CNT_W  high watermark, sampled in INIT
th_low_in  in  CNT_W  low watermark, sampled in INIT
fifo_count  in  NUM_CH*CNT_W  packed occupancy; channel i is at bits [i*CNT_W +: CNT_W]
fifo_empty  in  NUM_CH  per-channel empty flag
fifo_full  in  NUM_CH  per-channel full flag
fifo_wr  in  NUM_CH  per-channel push attempt
pause  out  NUM_CH  stop sending on the channel
continue  out  NUM_CH  one-cycle resume pulse
error_full  out  NUM_CH  sticky overflow flag
idle  out  1  high while the FSM is in IDLE
init_out  out  1  high while the FSM is in INIT
state_out  out  5  one-hot current state

Behaviour:
- States are one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
- While reset=0 (asynchronous): state=RESET, pause=0, continue=0, error_full=0, idle=0, init_out=0.
  - Threshold registers load TH_HIGH_DEF / TH_LOW_DEF.
- All outputs are registered. They are computed from next-state at the same edge, so outputs are valid in the first cycle of the new state.
- RESET -> INIT on the first clock edge after reset deasserts.
- INIT:
  - init_out=1, pause=0.
  - Latches th_high_in and th_low_in every cycle.
  - If th_low_in >= th_high_in, the latched low value is th_high_in-1, saturating at 0.
  - Stays in INIT while init=1. Goes to IDLE when init=0.
  - Clears all error_full bits.
- IDLE:
  - idle=1, pause=0.
  - Goes to ACTIVE if any fifo_empty bit is 0.
- ACTIVE, evaluated per channel i:
  - pause[i] sets when count_i >= th_high.
  - pause[i] clears when count_i <= th_low. Otherwise it holds its value.
  - continue[i]=1 for exactly one cycle on the edge where pause[i] falls 1->0.
  - Goes to IDLE when all fifo_empty bits are 1; pause clears and no continue pulse is generated.
- Overflow: fifo_wr[i] & fifo_full[i] in IDLE or ACTIVE:
  - Sets error_full[i] (sticky).
  - Next state is ERROR. This takes priority over init and over IDLE/ACTIVE transitions.
  - Simultaneous overflows on several channels set all of the corresponding bits.
- init=1 in IDLE or ACTIVE with no overflow: next state is INIT; pause and continue clear.
- ERROR:
  - pause is forced all-ones, continue=0.
  - Further overflows OR additional bits into error_full.
  - Exits only via init=1 -> INIT, or via reset.
- Count comparisons are unsigned, CNT_W bits wide. No wrap-around: count is bounded by the FIFO depth.

Optional Feature:
FSM_AUTO_RECOVER_EN
- Defined: ERROR -> INIT automatically once every channel with error_full set reports fifo_empty=1 for 2 consecutive cycles. init remains an immediate exit.
- Not defined: ERROR is left only by init or reset; there is no recovery counter logic.

Decomposition:
- Package fsm_flow_pkg holds:
  - the one-hot state localparams and the state width (5);
  - the default watermark constants;
  - a function that clamps the low watermark.
- Sub-module fsm_ch_hyst is instantiated NUM_CH times via generate.
  - Inputs: count_i, th_high, th_low, active, force_pause, clr.
  - Outputs: pause_i, continue_i.
  - Holds the per-channel hysteresis flop and the continue edge detect.
- The top level holds the state register, threshold registers, error_full register and (with the macro) the recovery counter.

Test Plan:
- Reset low 3 cycles, then high. Expect state RESET, then INIT, with init_out=1. Drop init: IDLE, idle=1. All other outputs 0 throughout.
- In INIT, th_high_in=5, th_low_in=1. Ramp ch2 count 0..6 then back to 0.
  - pause[2] rises in the cycle after count=5 is seen.
  - pause[2] falls after count=1 is seen, together with a single continue[2] pulse.
  - State returns to IDLE when all FIFOs are empty.
- In INIT, th_high_in=3, th_low_in=7. Latched th_low is 2. Count 4 then 2 on ch0: pause[0] set, then cleared at 2.
- In ACTIVE, fifo_full=4'b1001 and fifo_wr=4'b1001 in one cycle, with init=1 at the same time.
  - Expect ERROR and error_full=4'b1001; init is ignored that cycle.
  - pause=4'b1111, continue=0.
  - A second cycle with init=1 goes to INIT and clears error_full.
- Reset asserted mid-ACTIVE with pause=4'b0100: all outputs go to 0 immediately, without waiting for a clock edge. State is RESET.
- With FSM_AUTO_RECOVER_EN defined: ERROR with error_full=4'b0010. Set fifo_empty[1]=1 for 2 cycles: state moves to INIT without init. With the macro undefined, the same stimulus keeps the FSM in ERROR.
